// File: rtl/calc_pkg.sv
// calc_pkg: result-source encoding shared by the arbiter, its consumers and the bench
package calc_pkg;
  typedef logic [2:0] unit_t;
  localparam unit_t UNIT_ADD = 3'b001;
  localparam unit_t UNIT_SUB = 3'b010;
  localparam unit_t UNIT_MUL = 3'b100;
endpackage

// File: rtl/aging_arbiter_age_counter.sv
// age_counter: counts cycles a request waits, flags urgent at AGE_LIMIT
module age_counter #(
  parameter int AGE_LIMIT = 4,
  parameter int AGE_W = $clog2(AGE_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic urgent
);
  localparam logic [AGE_W-1:0] LIM = AGE_W'(AGE_LIMIT);
  logic [AGE_W-1:0] age;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age <= '0;
    else if (!req || gnt) age <= '0;
    else if (age != LIM) age <= age + 1'b1;
  assign urgent = req & (age == LIM);
endmodule

// File: rtl/aging_arbiter.sv
// aging_arbiter: add > sub > mul result arbiter with starvation aging and one-entry output register
module aging_arbiter
  import calc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int AGE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] c,
  input  logic             c_valid,
  output logic             c_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [2:0]       result_unit,
  input  logic             result_ack
);
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic       slot_free;
  logic [2:0] valid, urgent, req;
  unit_t      grant, ready;
  assign valid = {c_valid, b_valid, a_valid};
  assign slot_free = !result_valid | result_ack;
  assign req = |urgent ? urgent : valid;
  assign grant = req[0] ? UNIT_ADD : req[1] ? UNIT_SUB : req[2] ? UNIT_MUL : unit_t'(0);
  // readies stay low while reset is held even though the slot looks free
  assign ready = grant & {3{slot_free & rst_n}};
  assign {c_ready, b_ready, a_ready} = ready;
  for (genvar i = 0; i < 3; i++) begin : g_age
    age_counter #(.AGE_LIMIT(AGE_LIMIT), .AGE_W(AGE_W)) u_age (
      .clk(clk), .rst_n(rst_n), .req(valid[i]), .gnt(ready[i]), .urgent(urgent[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result <= '0;
      result_unit <= '0;
      result_valid <= 1'b0;
    end else if (|ready) begin
      result <= ready[0] ? a : ready[1] ? b : c;
      result_unit <= ready;
      result_valid <= 1'b1;
    end else if (result_ack) result_valid <= 1'b0;
endmodule

// File: tb/tb_aging_arbiter.sv
// tb_aging_arbiter: scoreboard bench for aging_arbiter
module tb_aging_arbiter;
  import calc_pkg::*;
  localparam int W = 64;
  logic clk = 0, rst_n = 0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic a_valid = 0, b_valid = 0, c_valid = 0;
  logic a_ready, b_ready, c_ready;
  logic [W-1:0] result;
  logic result_valid;
  logic [2:0] result_unit;
  logic result_ack = 0;
  int checks = 0, fails = 0;
  logic [W-1:0] src_a[$], src_b[$], src_c[$], exp_a[$], exp_b[$], exp_c[$];
  logic tk_a = 0, tk_b = 0, tk_c = 0;
  logic hold = 0, has = 0;
  logic [W-1:0] hold_res = '0, e = '0, r0 = '0;
  logic [2:0] hold_unit = '0;
  always #5 clk = ~clk;
  aging_arbiter #(.WIDTH(W), .AGE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready),
    .c(c), .c_valid(c_valid), .c_ready(c_ready),
    .result(result), .result_valid(result_valid), .result_unit(result_unit),
    .result_ack(result_ack)
  );
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic drain();
    int n = 0;
    while ((src_a.size() + src_b.size() + src_c.size() + exp_a.size() + exp_b.size() + exp_c.size() != 0 || result_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_a.size() + exp_b.size() + exp_c.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still expected, required 0", exp_a.size() + exp_b.size() + exp_c.size());
    end
  endtask
  task automatic test_reset();
    step();
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", result_valid); end
    checks++;
    if (result !== '0) begin fails++; $display("FAIL reset_result: got %h required 0", result); end
    checks++;
    if (result_unit !== 3'b000) begin fails++; $display("FAIL reset_unit: got %b required 000", result_unit); end
    checks++;
    if ({c_ready, b_ready, a_ready} !== 3'b000) begin fails++; $display("FAIL reset_ready: got %b required 000", {c_ready, b_ready, a_ready}); end
    step();
    rst_n = 1;
  endtask
  task automatic test_reset_mid_hold();
    result_ack = 0;
    src_a.push_back(W'(5));
    src_a.push_back(W'(5));
    exp_a.push_back(W'(5));
    step();
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (!result_valid || result !== W'(5) || a_ready !== 1'b0) begin fails++; $display("FAIL hold_before_reset: valid=%b result=%h a_ready=%b required 1/5/0", result_valid, result, a_ready); end
    step();
    rst_n = 0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || result !== '0 || result_unit !== 3'b000) begin fails++; $display("FAIL async_reset: valid=%b result=%h unit=%b required 0/0/000", result_valid, result, result_unit); end
    step();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b required 1", a_ready); end
    @(negedge clk);
    checks++;
    if (!result_valid || result !== W'(5) || result_unit !== UNIT_ADD) begin fails++; $display("FAIL result_after_reset: valid=%b result=%h unit=%b required 1/5/001", result_valid, result, result_unit); end
    step();
    result_ack = 1;
    drain();
  endtask
  task automatic test_priority();
    step();
    result_ack = 1;
    for (int i = 1; i <= 3; i++) begin
      src_a.push_back(W'(1)); exp_a.push_back(W'(1));
      break;
    end
    src_b.push_back(W'(2)); exp_b.push_back(W'(2));
    src_c.push_back(W'(3)); exp_c.push_back(W'(3));
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if ({c_ready, b_ready, a_ready} !== 3'(1 << i)) begin fails++; $display("FAIL prio_ready[%0d]: got %b required %b", i, {c_ready, b_ready, a_ready}, 3'(1 << i)); end
      end
      if (i > 0) begin
        checks++;
        if (!result_valid || result !== W'(i) || result_unit !== 3'(1 << (i - 1))) begin fails++; $display("FAIL prio_result[%0d]: got %h/%b required %0d/%b", i, result, result_unit, i, 3'(1 << (i - 1))); end
      end
    end
    drain();
  endtask
  task automatic test_starvation();
    int k = -1;
    step();
    result_ack = 1;
    for (int i = 0; i < 16; i++) begin
      src_a.push_back(W'(256 + i)); exp_a.push_back(W'(256 + i));
      src_b.push_back(W'(512 + i)); exp_b.push_back(W'(512 + i));
    end
    src_c.push_back(W'(64'hC0FFEE)); exp_c.push_back(W'(64'hC0FFEE));
    step();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (k >= 0 && i == k + 1) begin
        checks++;
        if (result !== W'(64'hC0FFEE) || result_unit !== UNIT_MUL) begin fails++; $display("FAIL starve_result: got %h/%b required c0ffee/100", result, result_unit); end
      end
      if (c_ready && k < 0) k = i;
    end
    checks++;
    if (k < 0 || k > 5) begin fails++; $display("FAIL starve_latency: c_ready at cycle %0d required 0..5", k); end
    drain();
  endtask
  task automatic test_backpressure();
    step();
    result_ack = 0;
    src_b.push_back(W'(16)); exp_b.push_back(W'(16));
    src_c.push_back(W'(12)); exp_c.push_back(W'(12));
    step();
    @(negedge clk);
    checks++;
    if ({c_ready, b_ready, a_ready} !== 3'b010) begin fails++; $display("FAIL bp_first: got %b required 010", {c_ready, b_ready, a_ready}); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (!result_valid || result !== W'(16) || result_unit !== UNIT_SUB || {c_ready, b_ready, a_ready} !== 3'b000) begin fails++; $display("FAIL bp_hold[%0d]: %b %h/%b ready=%b required 1 10/010 000", i, result_valid, result, result_unit, {c_ready, b_ready, a_ready}); end
    end
    step();
    result_ack = 1;
    @(negedge clk);
    checks++;
    if ({c_ready, b_ready, a_ready} !== 3'b100) begin fails++; $display("FAIL bp_release: got %b required 100", {c_ready, b_ready, a_ready}); end
    @(negedge clk);
    checks++;
    if (result !== W'(12) || result_unit !== UNIT_MUL) begin fails++; $display("FAIL bp_c_result: got %h/%b required c/100", result, result_unit); end
    drain();
  endtask
  task automatic test_throughput();
    step();
    result_ack = 1;
    for (int i = 0; i < 8; i++) begin src_a.push_back(W'(i)); exp_a.push_back(W'(i)); end
    step();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (a_ready !== 1'b1) begin fails++; $display("FAIL tput_ready[%0d]: got %b required 1", i, a_ready); end
      end
      if (i > 0) begin
        checks++;
        if (!result_valid || result !== W'(i - 1) || result_unit !== UNIT_ADD) begin fails++; $display("FAIL tput_result[%0d]: got %b %h/%b required 1 %0d/001", i, result_valid, result, result_unit, i - 1); end
      end
    end
    drain();
  endtask
  task automatic test_idle_ack();
    step();
    result_ack = 0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin fails++; $display("FAIL idle_pre: valid=%b required 0", result_valid); end
    r0 = result;
    for (int i = 0; i < 2; i++) begin
      step();
      result_ack = (i == 0);
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || result !== r0 || {c_ready, b_ready, a_ready} !== 3'b000) begin fails++; $display("FAIL idle_ack[%0d]: valid=%b result=%h ready=%b required 0/%h/000", i, result_valid, result, {c_ready, b_ready, a_ready}, r0); end
    end
  endtask
  initial begin
    fork
      forever begin
        @(posedge clk);
        #1;
        if (tk_a) src_a.delete(0);
        if (tk_b) src_b.delete(0);
        if (tk_c) src_c.delete(0);
        a_valid = src_a.size() != 0;
        b_valid = src_b.size() != 0;
        c_valid = src_c.size() != 0;
        a = a_valid ? src_a[0] : '0;
        b = b_valid ? src_b[0] : '0;
        c = c_valid ? src_c[0] : '0;
      end
      forever begin
        @(negedge clk);
        tk_a = a_ready;
        tk_b = b_ready;
        tk_c = c_ready;
        checks++;
        if ($countones({c_ready, b_ready, a_ready}) > 1) begin fails++; $display("FAIL one_ready: got %b required at most one high", {c_ready, b_ready, a_ready}); end
        if (result_valid) begin
          checks++;
          if (!$onehot(result_unit)) begin fails++; $display("FAIL unit_onehot: got %b required one-hot", result_unit); end
        end
        if (hold && result_valid) begin
          checks++;
          if (result !== hold_res || result_unit !== hold_unit) begin fails++; $display("FAIL hold_stable: got %h/%b required %h/%b", result, result_unit, hold_res, hold_unit); end
        end
        hold = rst_n && result_valid && !result_ack;
        hold_res = result;
        hold_unit = result_unit;
        if (rst_n && result_valid && result_ack) begin
          has = 1;
          e = '0;
          if (result_unit == UNIT_ADD && exp_a.size() != 0) e = exp_a.pop_front();
          else if (result_unit == UNIT_SUB && exp_b.size() != 0) e = exp_b.pop_front();
          else if (result_unit == UNIT_MUL && exp_c.size() != 0) e = exp_c.pop_front();
          else has = 0;
          checks++;
          if (!has || result !== e) begin fails++; $display("FAIL scoreboard: got %h from %b required %h (expected entry present=%b)", result, result_unit, e, has); end
        end
      end
      begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish before 100000");
        $fatal(1);
      end
    join_none
    test_reset();
    test_reset_mid_hold();
    test_priority();
    test_starvation();
    test_backpressure();
    test_throughput();
    test_idle_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
